denormalize: RTL and testbench
==============================

DENORMALIZE -- requirements
Module: denormalize

Interface
REQ-001 Parameter SIZE_MANTIS, default 26, mantissa width in bits.
REQ-002 Parameter SIZE_EXP, default 8, exponent width in bits.
REQ-003 The clock is clk (one clock; all state updates on its rising edge).
REQ-004 Reset is rst, asynchronous, active-high.
REQ-005 Port list, one per line: name  direction  width  meaning.
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands
- exp_a  input  SIZE_EXP  exponent of operand A
- mantis_a  input  SIZE_MANTIS  mantissa of operand A
- exp_b  input  SIZE_EXP  exponent of operand B
- mantis_b  input  SIZE_MANTIS  mantissa of operand B
- out_valid  output  1  aligned result available
- out_ready  input  1  consumer accepts result
- exp_out  output  SIZE_EXP  common (larger) exponent
- mantis_big  output  SIZE_MANTIS  mantissa of the larger-exponent operand, unshifted
- mantis_small  output  SIZE_MANTIS  mantissa of the smaller-exponent operand, right-shifted by the exponent difference
- sticky  output  1  OR of all bits shifted out of mantis_small
- swap  output  1  set when operand B had the larger exponent

Function
REQ-006 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE).
REQ-007 In IDLE, an in_valid&&in_ready cycle SHALL capture the operands; no other state accepts input, and in_valid outside IDLE SHALL be ignored.
REQ-008 On capture, if exp_a>=exp_b then big=A, small=B, swap=0, exp_out=exp_a, diff=exp_a-exp_b; otherwise big=B, small=A, swap=1, exp_out=exp_b, diff=exp_b-exp_a (equal exponents give swap=0).
REQ-009 On capture, sticky SHALL clear to 0.
REQ-010 On capture with diff==0, the next state SHALL be DONE.
REQ-011 On capture with 1<=diff<=SIZE_MANTIS, the next state SHALL be SHIFT with a shift counter loaded with diff; the counter SHALL be ceil(log2(SIZE_MANTIS+1)) bits wide.
REQ-012 On capture with diff>SIZE_MANTIS, mantis_small SHALL load 0, sticky SHALL load the OR-reduction of the small operand's mantissa, and the next state SHALL be DONE.
REQ-013 Each SHIFT cycle: mantis_small shifts right by one with zero fill; sticky |= bit shifted out; counter decrements; when the counter reaches 0 (after the final shift), the next state SHALL be DONE.
REQ-014 Latency, capture edge to out_valid high, SHALL be: 1 cycle for diff==0 or diff>SIZE_MANTIS; diff+1 cycles for 1<=diff<=SIZE_MANTIS.
REQ-015 out_valid SHALL equal (state==DONE); all result outputs SHALL be stable while out_valid is high.
REQ-016 In DONE with out_ready high, the next state SHALL be IDLE; with out_ready low, the block SHALL stay in DONE indefinitely.
REQ-017 mantis_big and exp_out SHALL never be modified outside capture.
REQ-018 For diff==SIZE_MANTIS, the final mantis_small SHALL be 0, with sticky equal to the OR of the original small mantissa.

Reset
REQ-019 While rst is high, state SHALL be IDLE and exp_out, mantis_big, mantis_small, sticky, swap, out_valid and the counter SHALL be 0.
REQ-020 rst asserted in any state, including mid-SHIFT, SHALL abort the operation with no result presented; in_ready SHALL be 1 in the first cycle after release.

Verification (SIZE_MANTIS=26, SIZE_EXP=8)
REQ-021 Equal exponents: exp_a=exp_b=8'h80, mantis_a=26'h2000000, mantis_b=26'h3000000 -> out_valid 1 cycle after capture, exp_out=8'h80, big=26'h2000000, small=26'h3000000, sticky=0, swap=0.
REQ-022 Shift with sticky: exp_a=8'h83, mantis_a=26'h2000000, exp_b=8'h80, mantis_b=26'h2000005 -> out_valid 4 cycles after capture, exp_out=8'h83, small=26'h0400000, sticky=1, swap=0.
REQ-023 Swap: exp_a=8'h10, mantis_a=26'h0000004, exp_b=8'h12, mantis_b=26'h0000001 -> out_valid 3 cycles after capture, swap=1, exp_out=8'h12, big=26'h0000001, small=26'h0000001, sticky=0.
REQ-024 Large difference: exp_a=8'hFF, exp_b=8'h00, mantis_b=26'h0000001 -> out_valid 1 cycle after capture, small=0, sticky=1, exp_out=8'hFF.
REQ-025 Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> outputs unchanged, in_ready=0, new operands not captured; out_ready=1 -> IDLE next cycle.
REQ-026 Reset mid-SHIFT: assert rst during the 2nd shift cycle of REQ-022 -> all outputs 0 immediately, out_valid never rises, in_ready=1 the first cycle after release.

Source files
------------

// File: rtl/denormalize.sv
// Floating-point operand alignment.
// Takes two (exponent, mantissa) pairs, selects the operand with the larger
// exponent, and right-shifts the other mantissa one bit per cycle until both
// share the larger exponent. Every bit shifted out is OR-ed into sticky.
//
// Handshake: an input pair transfers on a cycle where in_valid && in_ready.
// A result transfers on a cycle where out_valid && out_ready. in_ready is
// high only in IDLE and out_valid only in DONE. The result outputs are held
// stable for as long as out_valid is high.
module denormalize #(
    parameter int SIZE_MANTIS = 26,
    parameter int SIZE_EXP    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE_EXP-1:0]    exp_a,
    input  logic [SIZE_MANTIS-1:0] mantis_a,
    input  logic [SIZE_EXP-1:0]    exp_b,
    input  logic [SIZE_MANTIS-1:0] mantis_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE_EXP-1:0]    exp_out,
    output logic [SIZE_MANTIS-1:0] mantis_big,
    output logic [SIZE_MANTIS-1:0] mantis_small,
    output logic                   sticky,
    output logic                   swap
);

    // The counter must hold every shift distance from 1 to SIZE_MANTIS.
    localparam int CNT_W = $clog2(SIZE_MANTIS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;

    logic                     a_big;
    logic [SIZE_EXP-1:0]      diff;
    logic [SIZE_MANTIS-1:0]   small_in;
    logic                     too_far;

    // Operand ordering and shift distance from the live inputs, used only on capture.
    always_comb begin
        a_big    = (exp_a >= exp_b);
        diff     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
        small_in = a_big ? mantis_b : mantis_a;
        // Beyond SIZE_MANTIS every bit falls off, so skip the shifting entirely.
        too_far  = (32'(diff) > 32'(SIZE_MANTIS));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Alignment FSM: capture in IDLE, one-bit shifts in SHIFT, hold in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            exp_out      <= '0;
            mantis_big   <= '0;
            mantis_small <= '0;
            sticky       <= 1'b0;
            swap         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        exp_out    <= a_big ? exp_a : exp_b;
                        mantis_big <= a_big ? mantis_a : mantis_b;
                        swap       <= ~a_big;
                        sticky     <= 1'b0;
                        cnt        <= '0;
                        if (diff == '0) begin
                            mantis_small <= small_in;
                            state        <= DONE;
                        end else if (too_far) begin
                            mantis_small <= '0;
                            sticky       <= |small_in;
                            state        <= DONE;
                        end else begin
                            mantis_small <= small_in;
                            cnt          <= CNT_W'(diff);
                            state        <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mantis_small <= mantis_small >> 1;
                    sticky       <= sticky | mantis_small[0];
                    cnt          <= cnt - CNT_W'(1);
                    // cnt==1 means this is the last shift.
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_denormalize.sv
// Directed testbench for denormalize with SIZE_MANTIS=26, SIZE_EXP=8.
module tb_denormalize;

    localparam int SM = 26;
    localparam int SE = 8;
    localparam int RW = SE + SM + SM + 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SE-1:0] exp_a;
    logic [SM-1:0] mantis_a;
    logic [SE-1:0] exp_b;
    logic [SM-1:0] mantis_b;
    logic          out_valid;
    logic          out_ready;
    logic [SE-1:0] exp_out;
    logic [SM-1:0] mantis_big;
    logic [SM-1:0] mantis_small;
    logic          sticky;
    logic          swap;

    int checks;
    int errors;

    denormalize #(.SIZE_MANTIS(SM), .SIZE_EXP(SE)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exp_a        (exp_a),
        .mantis_a     (mantis_a),
        .exp_b        (exp_b),
        .mantis_b     (mantis_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .exp_out      (exp_out),
        .mantis_big   (mantis_big),
        .mantis_small (mantis_small),
        .sticky       (sticky),
        .swap         (swap)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] result_now();
        return {exp_out, mantis_big, mantis_small, sticky, swap};
    endfunction

    // Offer one operand pair and count edges from the capture edge (edge 1)
    // until out_valid is seen; gives up after 100 edges.
    task automatic run_op(input logic [SE-1:0] ea, input logic [SM-1:0] ma,
                          input logic [SE-1:0] eb, input logic [SM-1:0] mb,
                          output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        exp_a = ea; mantis_a = ma; exp_b = eb; mantis_b = mb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Accept the held result and confirm return to IDLE.
    task automatic pop(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_pop: {out_valid,in_ready}=%b required 01", name, {out_valid, in_ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake: {in_ready,out_valid}=%b required 10", {in_ready, out_valid});
        end
        checks++;
        if (result_now() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", result_now());
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_equal();
        int lat;
        run_op(8'h80, 26'h2000000, 8'h80, 26'h3000000, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL equal_latency: got %0d required 1", lat);
        end
        checks++;
        if (result_now() !== {8'h80, 26'h2000000, 26'h3000000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL equal_result: got %h required %h", result_now(),
                     {8'h80, 26'h2000000, 26'h3000000, 1'b0, 1'b0});
        end
        pop("equal");
    endtask

    task automatic test_shift_sticky();
        int lat;
        run_op(8'h83, 26'h2000000, 8'h80, 26'h2000005, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL shift_latency: got %0d required 4", lat);
        end
        checks++;
        if (result_now() !== {8'h83, 26'h2000000, 26'h0400000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL shift_result: got %h required %h", result_now(),
                     {8'h83, 26'h2000000, 26'h0400000, 1'b1, 1'b0});
        end
        pop("shift");
    endtask

    task automatic test_swap();
        int lat;
        run_op(8'h10, 26'h0000004, 8'h12, 26'h0000001, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL swap_latency: got %0d required 3", lat);
        end
        checks++;
        if (result_now() !== {8'h12, 26'h0000001, 26'h0000001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL swap_result: got %h required %h", result_now(),
                     {8'h12, 26'h0000001, 26'h0000001, 1'b0, 1'b1});
        end
        pop("swap");
    endtask

    task automatic test_large_diff();
        int lat;
        // diff=255: everything falls off, sticky from the nonzero small mantissa
        run_op(8'hFF, 26'h1234567, 8'h00, 26'h0000001, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL large_latency: got %0d required 1", lat);
        end
        checks++;
        if (result_now() !== {8'hFF, 26'h1234567, 26'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL large_result: got %h required %h", result_now(),
                     {8'hFF, 26'h1234567, 26'h0, 1'b1, 1'b0});
        end
        pop("large");
        // diff=64 with a zero small mantissa: sticky stays clear
        run_op(8'h00, 26'h0000000, 8'h40, 26'h0ABCDEF, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL large_zero_latency: got %0d required 1", lat);
        end
        checks++;
        if (result_now() !== {8'h40, 26'h0ABCDEF, 26'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL large_zero_result: got %h required %h", result_now(),
                     {8'h40, 26'h0ABCDEF, 26'h0, 1'b0, 1'b1});
        end
        pop("large_zero");
    endtask

    task automatic test_boundary();
        int lat;
        // diff=26: shifted the full width, small ends at 0
        run_op(8'h1A, 26'h0000001, 8'h00, 26'h2000000, lat);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL diff26_latency: got %0d required 27", lat);
        end
        checks++;
        if (result_now() !== {8'h1A, 26'h0000001, 26'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL diff26_result: got %h required %h", result_now(),
                     {8'h1A, 26'h0000001, 26'h0, 1'b1, 1'b0});
        end
        pop("diff26");
        // diff=27: first distance handled without shifting
        run_op(8'h1B, 26'h0000002, 8'h00, 26'h0000100, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL diff27_latency: got %0d required 1", lat);
        end
        checks++;
        if (result_now() !== {8'h1B, 26'h0000002, 26'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL diff27_result: got %h required %h", result_now(),
                     {8'h1B, 26'h0000002, 26'h0, 1'b1, 1'b0});
        end
        pop("diff27");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [RW-1:0] held;
        held = {8'h21, 26'h1000000, 26'h0C00000, 1'b0, 1'b0};
        run_op(8'h21, 26'h1000000, 8'h20, 26'h1800000, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 2", lat);
        end
        for (int i = 0; i < 5; i++) begin
            exp_a = 8'h05; mantis_a = 26'h3FFFFFF;
            exp_b = 8'h70; mantis_b = 26'h1111111;
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, result_now()} !== {1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got %b_%b_%h required 1_0_%h", i,
                         out_valid, in_ready, result_now(), held);
            end
        end
        in_valid = 1'b0;
        pop("bp");
        checks++;
        if (result_now() !== held) begin
            errors++;
            $display("FAIL bp_not_captured: got %h required %h", result_now(), held);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(8'h02, 26'h0000008, 8'h02, 26'h0000003, lat);
        pop("b2b_first");
        run_op(8'h40, 26'h0000003, 8'h41, 26'h3FFFFFF, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL b2b_latency: got %0d required 2", lat);
        end
        checks++;
        if (result_now() !== {8'h41, 26'h3FFFFFF, 26'h0000001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_result: got %h required %h", result_now(),
                     {8'h41, 26'h3FFFFFF, 26'h0000001, 1'b1, 1'b1});
        end
        pop("b2b_second");
    endtask

    task automatic test_reset_mid_shift();
        logic seen_valid;
        seen_valid = 1'b0;
        exp_a = 8'h83; mantis_a = 26'h2000000;
        exp_b = 8'h80; mantis_b = 26'h2000005;
        in_valid = 1'b1;
        @(posedge clk); #1;           // captured: first shift cycle
        in_valid = 1'b0;
        @(posedge clk); #1;           // second shift cycle
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, result_now()} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b_%b_%h required 0_1_0",
                     out_valid, in_ready, result_now());
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release: in_ready=%b required 1", in_ready);
        end
        repeat (6) begin
            if (out_valid) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_result: out_valid seen=%b required 0", seen_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_a     = '0;
        mantis_a  = '0;
        exp_b     = '0;
        mantis_b  = '0;
        test_reset();
        test_equal();
        test_shift_sticky();
        test_swap();
        test_large_diff();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
